// File: rtl/crt_clk_div_gen.sv
// CRT clock divider: crt_clk = pix_clk / (ratio+1), ratio loaded by req/ack.
// Ports: pix_clk, hb_resetn | div_ratio, div_req -> div_ack, div_busy,
//   active_ratio, crt_clk, crt_phase.
// Option: define CRT_DIV_HALF_DUTY_EN for ~50% duty crt_clk.
module crt_clk_div_gen #(
  parameter int DIV_W       = 4,
  parameter int RESET_RATIO = 0
) (
  input  logic             pix_clk,
  input  logic             hb_resetn,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_req,
  output logic             div_ack,
  output logic             div_busy,
  output logic [DIV_W-1:0] active_ratio,
  output logic             crt_clk,
  output logic [DIV_W-1:0] crt_phase
);

  localparam logic [DIV_W-1:0] RST_R =
    RESET_RATIO[DIV_W-1:0];

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_ratio;
  logic             tc;
  logic             apply;
  logic             clk_nxt;

  assign tc        = (cnt == active_ratio);
  // A live request always beats the apply.
  assign apply     = div_busy && !div_req && tc;
  assign crt_phase = cnt;

`ifdef CRT_DIV_HALF_DUTY_EN
  logic [DIV_W:0] half;
  // ceil((ratio+1)/2) == (ratio+2)>>1
  assign half    = ({1'b0, active_ratio} + (DIV_W+1)'(2)) >> 1;
  assign clk_nxt = ({1'b0, cnt} < half);
`else
  assign clk_nxt = (cnt == '0);
`endif

  always_ff @(posedge pix_clk or negedge hb_resetn) begin
    if (!hb_resetn) begin
      cnt          <= '0;
      active_ratio <= RST_R;
      pend_ratio   <= '0;
      div_busy     <= 1'b0;
      div_ack      <= 1'b0;
      crt_clk      <= 1'b1;
    end else begin
      crt_clk <= clk_nxt;
      div_ack <= apply;
      if (div_req) begin
        pend_ratio <= div_ratio;
        div_busy   <= 1'b1;
      end
      if (apply) begin
        active_ratio <= pend_ratio;
        cnt          <= '0;
        div_busy     <= 1'b0;
      end else if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crt_clk_div_gen.sv
// Self-checking bench for crt_clk_div_gen.
// Scoreboard of per-cycle expected outputs plus directed checks.
module tb_crt_clk_div_gen;

  localparam int W = 4;

  logic         pix_clk = 1'b0;
  logic         hb_resetn;
  logic [W-1:0] div_ratio;
  logic         div_req;
  logic         div_ack;
  logic         div_busy;
  logic [W-1:0] active_ratio;
  logic         crt_clk;
  logic [W-1:0] crt_phase;

  crt_clk_div_gen #(.DIV_W(W), .RESET_RATIO(0)) dut (
    .pix_clk      (pix_clk),
    .hb_resetn    (hb_resetn),
    .div_ratio    (div_ratio),
    .div_req      (div_req),
    .div_ack      (div_ack),
    .div_busy     (div_busy),
    .active_ratio (active_ratio),
    .crt_clk      (crt_clk),
    .crt_phase    (crt_phase)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic         ack;
    logic         busy;
    logic         clk;
    logic [W-1:0] act;
    logic [W-1:0] ph;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_cnt, m_act, m_pend;
  bit m_busy, m_ack, m_clk;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_act = 0; m_pend = 0;
    m_busy = 0; m_ack = 0; m_clk = 1;
  endtask

  task automatic m_edge(bit req, int ratio);
    bit tc, ap;
    tc = (m_cnt == m_act);
    ap = m_busy && !req && tc;
`ifdef CRT_DIV_HALF_DUTY_EN
    m_clk = (m_cnt < (m_act + 2) / 2);
`else
    m_clk = (m_cnt == 0);
`endif
    m_ack = ap;
    if (req) begin
      m_pend = ratio;
      m_busy = 1;
    end
    if (ap) begin
      m_act = m_pend; m_cnt = 0; m_busy = 0;
    end else if (tc) m_cnt = 0;
    else m_cnt = m_cnt + 1;
  endtask

  // One pix_clk cycle: drive, model, push, sample, pop, compare.
  task automatic step(bit req, int ratio);
    exp_t e;
    div_req   = req;
    div_ratio = W'(ratio);
    @(posedge pix_clk);
    m_edge(req, ratio);
    q.push_back({m_ack, m_busy, m_clk, W'(m_act), W'(m_cnt)});
    #1;
    e = q.pop_front();
    check("sb_ack", div_ack, e.ack);
    check("sb_busy", div_busy, e.busy);
    check("sb_clk", crt_clk, e.clk);
    check("sb_act", active_ratio, e.act);
    check("sb_phase", crt_phase, e.ph);
  endtask

  task automatic wait_ack(string tag);
    int n = 0;
    while (!div_ack && n < 40) begin
      step(0, 0);
      n++;
    end
    check(tag, div_ack, 1);
  endtask

  task automatic wait_phase(string tag, int ph);
    int n = 0;
    while (crt_phase != W'(ph) && n < 40) begin
      step(0, 0);
      n++;
    end
    check(tag, crt_phase, ph);
  endtask

  int lat, acks, highs, maxph, r1, r2, cyc;
  bit seen, prev;

  initial begin
    hb_resetn = 0; div_req = 0; div_ratio = '0;
    m_reset();
    #12;
    check("rst_clk", crt_clk, 1);
    check("rst_phase", crt_phase, 0);
    check("rst_busy", div_busy, 0);
    check("rst_ack", div_ack, 0);
    check("rst_act", active_ratio, 0);
    hb_resetn = 1;
    repeat (4) step(0, 0);
    check("r0_clk_hi", crt_clk, 1);

    // ratio 0 -> 3
    step(1, 3);
    check("t2_busy", div_busy, 1);
    step(0, 0);
    check("t2_ack", div_ack, 1);
    check("t2_act", active_ratio, 3);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      highs += crt_clk;
    end
`ifdef CRT_DIV_HALF_DUTY_EN
    check("t2_highs", highs, 4);
`else
    check("t2_highs", highs, 2);
`endif

    // ratio 3 -> 1 requested at cnt=1
    wait_phase("t3_ph1", 1);
    step(1, 1);
    lat = 0;
    while (!div_ack && lat < 10) begin
      step(0, 0);
      lat++;
    end
    check("t3_lat", lat, 2);
    check("t3_act", active_ratio, 1);
    repeat (6) step(0, 0);

    // held request 5,6,7
    step(1, 5); step(1, 6); step(1, 7);
    acks = 0; seen = 0; r1 = -1; r2 = -1; prev = crt_clk;
    for (int i = 0; i < 40; i++) begin
      step(0, 0);
      acks += div_ack;
      if (div_ack) seen = 1;
      if (seen && crt_clk && !prev) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = crt_clk;
    end
    check("t4_acks", acks, 1);
    check("t4_act", active_ratio, 7);
    check("t4_period", r2 - r1, 8);

    // ratio 15
    step(1, 15);
    wait_ack("t5_ack");
    highs = 0; maxph = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0);
      highs += crt_clk;
      if (crt_phase > maxph) maxph = crt_phase;
    end
`ifdef CRT_DIV_HALF_DUTY_EN
    check("t5_highs", highs, 8);
`else
    check("t5_highs", highs, 1);
`endif
    check("t5_maxph", maxph, 15);
    check("t5_wrap", crt_phase, 0);

    // reset with pending load
    step(1, 3);
    wait_ack("t6_ack3");
    wait_phase("t6_ph1", 1);
    step(1, 9);
    check("t6_busy", div_busy, 1);
    check("t6_ph2", crt_phase, 2);
    hb_resetn = 0;
    #1;
    m_reset();
    check("t6_rst_busy", div_busy, 0);
    check("t6_rst_ph", crt_phase, 0);
    check("t6_rst_clk", crt_clk, 1);
    check("t6_rst_act", active_ratio, 0);
    check("t6_rst_ack", div_ack, 0);
    #3;
    hb_resetn = 1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      acks += div_ack;
    end
    check("t6_no_ack", acks, 0);
    check("t6_act", active_ratio, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
